// File: rtl/ca2_a_signo_magnitud.sv
// ca2_a_signo_magnitud: bit-serial (LSB first) two's complement -> sign/magnitude converter, rev 1.0
// Optional macro CA2_SM_MINNEG_EN adds the min_neg output flag.
`default_nettype none

module ca2_a_signo_magnitud #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] din,
  output logic             busy,
  output logic             done,
  output logic             sign,
  output logic [WIDTH-1:0] mag
`ifdef CA2_SM_MINNEG_EN
  ,
  output logic             min_neg
`endif
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   shift_q;
  logic [WIDTH-1:0]   res_q;
  logic [WIDTH-1:0]   res_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               seen_q;
  logic               sign_q;
  logic               out_sign_q;
  logic [WIDTH-1:0]   mag_q;
  logic               bit_o;
  logic               last_bit;
`ifdef CA2_SM_MINNEG_EN
  logic               minneg_cap_q;
  logic               minneg_q;
`endif

  // Negative operands: copy bits up to and including the first 1, invert the rest.
  always_comb begin
    bit_o    = shift_q[0];
    res_d    = res_q;
    last_bit = 1'b0;
    if (sign_q && seen_q) begin
      bit_o = ~shift_q[0];
    end
    res_d    = {bit_o, res_q[WIDTH-1:1]};
    last_bit = (cnt_q == CNT_W'(WIDTH - 1));
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_SHIFT;
      S_SHIFT: if (last_bit) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q      <= '0;
      res_q        <= '0;
      cnt_q        <= '0;
      seen_q       <= 1'b0;
      sign_q       <= 1'b0;
      out_sign_q   <= 1'b0;
      mag_q        <= '0;
`ifdef CA2_SM_MINNEG_EN
      minneg_cap_q <= 1'b0;
      minneg_q     <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            shift_q      <= din;
            sign_q       <= din[WIDTH-1];
            cnt_q        <= '0;
            seen_q       <= 1'b0;
            res_q        <= '0;
`ifdef CA2_SM_MINNEG_EN
            minneg_cap_q <= (din == {1'b1, {(WIDTH-1){1'b0}}});
`endif
          end
        end
        S_SHIFT: begin
          seen_q  <= seen_q | shift_q[0];
          res_q   <= res_d;
          shift_q <= shift_q >> 1;
          cnt_q   <= cnt_q + CNT_W'(1);
          // Results only become visible once the final bit is in.
          if (last_bit) begin
            mag_q      <= res_d;
            out_sign_q <= sign_q;
`ifdef CA2_SM_MINNEG_EN
            minneg_q   <= minneg_cap_q;
`endif
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);
  assign sign = out_sign_q;
  assign mag  = mag_q;
`ifdef CA2_SM_MINNEG_EN
  assign min_neg = minneg_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ca2_a_signo_magnitud.sv
// Self-checking bench for ca2_a_signo_magnitud (WIDTH = 4): cycle model plus directed literal checks.
`default_nettype none

module tb_ca2_a_signo_magnitud;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] din;
  logic         busy;
  logic         done;
  logic         sign;
  logic [W-1:0] mag;
`ifdef CA2_SM_MINNEG_EN
  logic         min_neg;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 0;

  ca2_a_signo_magnitud #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .din   (din),
    .busy  (busy),
    .done  (done),
    .sign  (sign),
    .mag   (mag)
`ifdef CA2_SM_MINNEG_EN
    ,
    .min_neg (min_neg)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: an accepted operand produces its sign/|value| after W+1 cycles.
  int           m_left = 0;
  logic         m_sign = 0, p_sign = 0;
  logic [W-1:0] m_mag = 0, p_mag = 0;
  logic         m_min = 0, p_min = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_left = 0; m_sign = 0; m_mag = 0; m_min = 0;
    end else if (m_left == 0) begin
      if (start) begin
        int v;
        v = $signed(din);
        m_left = W + 1;
        p_sign = (v < 0);
        p_mag  = (v < 0) ? W'(-v) : W'(v);
        p_min  = (v == -(1 << (W - 1)));
      end
    end else begin
      m_left = m_left - 1;
      if (m_left == 1) begin
        m_sign = p_sign; m_mag = p_mag; m_min = p_min;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 32'(busy), 32'(m_left != 0));
      chk("done", 32'(done), 32'(m_left == 1));
      chk("sign", 32'(sign), 32'(m_sign));
      chk("mag",  32'(mag),  32'(m_mag));
`ifdef CA2_SM_MINNEG_EN
      chk("min_neg", 32'(min_neg), 32'(m_min));
`endif
    end
  end

  // Runs one conversion; returns at the negedge where done is observed.
  task automatic convert(input logic [W-1:0] d, input bit pulse_mid, input bit lit,
                         input logic exp_s, input logic [W-1:0] exp_m, input logic exp_min);
    int k;
    @(negedge clk);
    din = d; start = 1'b1;
    @(negedge clk);
    start = 1'b0; din = ~d;
    k = 1;
    while (done !== 1'b1 && k < 20) begin
      if (pulse_mid) start = (k == 2);
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    if (k >= 20) begin
      chk("done_timeout", 32'(done), 32'd1);
    end else if (lit) begin
      chk("latency", 32'(k), 32'(W + 1));
      chk("lit_sign", 32'(sign), 32'(exp_s));
      chk("lit_mag", 32'(mag), 32'(exp_m));
`ifdef CA2_SM_MINNEG_EN
      chk("lit_min_neg", 32'(min_neg), 32'(exp_min));
`else
      if (exp_min === 1'bx) chk("lit_min_neg", 32'(0), 32'(1));
`endif
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; din = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sign", 32'(sign), 32'd0);
    chk("rst_mag",  32'(mag),  32'd0);

    convert(4'b0101, 1'b0, 1'b1, 1'b0, 4'b0101, 1'b0);
    convert(4'b1011, 1'b0, 1'b1, 1'b1, 4'b0101, 1'b0);
    convert(4'b1111, 1'b0, 1'b1, 1'b1, 4'b0001, 1'b0);
    convert(4'b1000, 1'b0, 1'b1, 1'b1, 4'b1000, 1'b1);
    convert(4'b0101, 1'b0, 1'b1, 1'b0, 4'b0101, 1'b0);
    convert(4'b0000, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0);
    convert(4'b0111, 1'b0, 1'b1, 1'b0, 4'b0111, 1'b0);

    for (int i = 0; i < 16; i++) begin
      convert(W'(i), 1'b1, 1'b0, 1'b0, '0, 1'b0);
    end

    // start held high: back-to-back conversions with an IDLE cycle between.
    @(negedge clk);
    din = 4'b1100; start = 1'b1;
    repeat (14) @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);

    // Reset at the second SHIFT cycle abandons the conversion.
    din = 4'b1010; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_sign", 32'(sign), 32'd0);
    chk("midrst_mag",  32'(mag),  32'd0);
    repeat (10) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ca2_a_signo_magnitud.md
Name: ca2_a_signo_magnitud

Overview:
- Bit-serial converter from WIDTH-bit two's complement to sign + magnitude. It is the inverse direction of the team's two's-complement encoder.
- Sits between the button-capture logic (switch value treated as signed) and the LED/7-segment display path, which needs an explicit sign and an unsigned magnitude.
- Processes one bit per clock, LSB first, using the "copy up to and including the first 1, invert the rest" rule for negative inputs.
- Start/busy/done handshake.

Parameters:
- WIDTH, 4, data width in bits; legal range 2..16.

Ports:
- clk  input  1  system clock, all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request conversion of din; sampled only in IDLE.
- din  input  WIDTH  two's-complement operand, captured on the accepting edge.
- busy  output  1  high while a conversion is in progress (SHIFT or DONE).
- done  output  1  one-cycle pulse; sign/mag valid from this cycle on.
- sign  output  1  1 = captured operand was negative.
- mag  output  WIDTH  unsigned magnitude; -2^(WIDTH-1) gives 1 followed by zeros, so no overflow.

Behaviour:
- Interface: one clock clk; reset rst is synchronous and active-high.
- Reset (rst high at a rising edge), effective from the next cycle:
  - state = IDLE; busy = 0, done = 0, sign = 0, mag = 0.
  - Internal shift register, result register, bit counter and seen_one flag cleared.
  - rst has priority over every other input.
- State machine (IDLE, SHIFT, DONE), binary encoded:
  - IDLE, start = 1 at an edge:
    - shift_reg <= din; sign_q <= din[WIDTH-1].
    - cnt <= 0; seen_one <= 0; res <= 0.
    - Go to SHIFT.
  - IDLE, start = 0: stay in IDLE.
  - SHIFT, one bit per edge, with b = shift_reg[0]:
    - Output bit o = b if sign_q = 0, or if seen_one = 0.
    - Otherwise o = ~b.
    - seen_one <= seen_one | b.
    - res <= {o, res[WIDTH-1:1]}; shift_reg <= shift_reg >> 1; cnt <= cnt + 1.
    - When cnt = WIDTH-1, the final bit is processed on that edge and the state goes to DONE.
  - On the SHIFT->DONE edge:
    - mag <= final result, including the bit processed on that edge.
    - sign <= sign_q.
  - DONE: done = 1 for exactly this one cycle, then go to IDLE.
- Latency: start sampled at edge E0 -> done high in the cycle after edge E(WIDTH). For WIDTH = 4, done is seen 5 edges after start.
- busy = 1 in SHIFT and DONE, 0 in IDLE. It is a registered/state-decoded output, glitch-free.
- start while busy: ignored entirely, with no queuing. start held high continuously gives back-to-back conversions with one IDLE cycle between them.
- din changes after capture have no effect on the current conversion.
- sign/mag hold their last result until the next SHIFT->DONE edge or reset. They do not change during SHIFT.
- Zero input: sign = 0, mag = 0; done still pulses.
- cnt width: clog2(WIDTH)+1 bits; it never wraps within a conversion.
- Reset mid-SHIFT: conversion is abandoned, no done pulse, outputs cleared.

Optional Feature:
- Macro: CA2_SM_MINNEG_EN.
- Defined:
  - Adds output port min_neg (1 bit, reset 0), updated on the same edge as mag.
  - min_neg = 1 iff the captured din was 1 followed by WIDTH-1 zeros, i.e. a magnitude not representable as a positive WIDTH-bit signed value.
  - Display logic uses it to flag the value.
- Undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
- rst for 2 cycles, then idle -> busy = 0, done = 0, sign = 0, mag = 0000.
- WIDTH = 4, din = 0101, start 1 cycle -> done 5 edges later; sign = 0, mag = 0101; busy high for 5 cycles.
- Negative inputs:
  - din = 1011 -> sign = 1, mag = 0101.
  - din = 1111 -> sign = 1, mag = 0001.
  - din = 1000 -> sign = 1, mag = 1000, min_neg = 1 with CA2_SM_MINNEG_EN; 0101 gives min_neg = 0.
- Exhaustive sweep of din 0..15 -> every result matches the reference model (sign = din[3], mag = |signed din|). start is pulsed during SHIFT and is ignored, with no extra done.
- rst asserted at the 2nd SHIFT cycle of din = 1010 -> next cycle IDLE, mag = 0000, sign = 0, and no done pulse ever appears.
